// File: rtl/qtable_pkg.sv
// rtl/qtable_pkg.sv - FSM encoding and address/compare helpers for the Q-value table
package qtable_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } qt_state_e;

    // Table address is {state, action}; callers cast the result to their address width.
    function automatic logic [31:0] qt_pack_addr(input logic [31:0] state,
                                                 input logic [31:0] action,
                                                 input int          action_bits);
        return (state << action_bits) | action;
    endfunction

    // a > b on width-bit operands given zero-extended to 32 bits.
    function automatic logic qt_greater(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input int          width,
                                        input logic        is_signed);
        logic [31:0] ext_mask;
        logic [31:0] a_ext;
        logic [31:0] b_ext;
        ext_mask = ~((32'd1 << width) - 32'd1);
        a_ext = (is_signed && (((a >> (width - 1)) & 32'd1) != 32'd0)) ? (a | ext_mask) : a;
        b_ext = (is_signed && (((b >> (width - 1)) & 32'd1) != 32'd0)) ? (b | ext_mask) : b;
        if (is_signed) begin
            return $signed(a_ext) > $signed(b_ext);
        end
        return a_ext > b_ext;
    endfunction

endpackage

// File: rtl/qtable_sdp_ram.sv
// rtl/qtable_sdp_ram.sv - 1W/1R synchronous RAM with registered read, no reset
module qtable_sdp_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Read-first on collision; the owner supplies write-first forwarding.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/qtable_maxq.sv
// rtl/qtable_maxq.sv - Q-value table with hardware clear, write-first reads and max-query scan
module qtable_maxq
    import qtable_pkg::*;
#(
    parameter int STATE_BITS  = 6,
    parameter int ACTION_BITS = 2,
    parameter int DATA_WIDTH  = 8,
    parameter int SIGNED_Q    = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic                   o_init_done,
    input  logic                   i_rd_valid,
    output logic                   o_rd_ready,
    input  logic [STATE_BITS-1:0]  i_rd_state,
    input  logic [ACTION_BITS-1:0] i_rd_action,
    output logic                   o_rd_valid,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_wr_en,
    input  logic [STATE_BITS-1:0]  i_wr_state,
    input  logic [ACTION_BITS-1:0] i_wr_action,
    input  logic [DATA_WIDTH-1:0]  i_wr_data,
    input  logic                   i_mq_valid,
    output logic                   o_mq_ready,
    input  logic [STATE_BITS-1:0]  i_mq_state,
    output logic                   o_mq_valid,
    output logic [DATA_WIDTH-1:0]  o_mq_value,
    output logic [ACTION_BITS-1:0] o_mq_action
);

    localparam int   ADDR_WIDTH = STATE_BITS + ACTION_BITS;
    localparam int   CNT_W      = ACTION_BITS + 1;
    localparam logic L_SIGNED   = (SIGNED_Q != 0);

    qt_state_e r_state;
    qt_state_e w_state_nxt;

    logic [ADDR_WIDTH-1:0]  r_init_addr;
    logic                   r_init_done;
    logic [STATE_BITS-1:0]  r_mq_state;
    logic [CNT_W-1:0]       r_scan_cnt;
    logic [DATA_WIDTH-1:0]  r_best_val;
    logic [ACTION_BITS-1:0] r_best_act;
    logic                   r_rd_valid;
    logic [DATA_WIDTH-1:0]  r_rd_hold;
    logic                   r_fwd_hit;
    logic [DATA_WIDTH-1:0]  r_fwd_data;
    logic                   r_mq_valid;
    logic [DATA_WIDTH-1:0]  r_mq_value;
    logic [ACTION_BITS-1:0] r_mq_action;

    logic                   w_ram_we;
    logic                   w_ram_re;
    logic [ADDR_WIDTH-1:0]  w_ram_waddr;
    logic [ADDR_WIDTH-1:0]  w_ram_raddr;
    logic [DATA_WIDTH-1:0]  w_ram_wdata;
    logic [DATA_WIDTH-1:0]  w_ram_rdata;
    logic [DATA_WIDTH-1:0]  w_rdata;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [ADDR_WIDTH-1:0]  w_rd_addr;
    logic [ADDR_WIDTH-1:0]  w_scan_addr;
    logic                   w_rd_accept;
    logic                   w_mq_accept;
    logic                   w_scan_issue;
    logic                   w_scan_cmp;
    logic                   w_scan_last;
    logic                   w_take;
    logic [ACTION_BITS-1:0] w_cmp_act;

    assign w_wr_addr   = ADDR_WIDTH'(qt_pack_addr(32'(i_wr_state), 32'(i_wr_action), ACTION_BITS));
    assign w_rd_addr   = ADDR_WIDTH'(qt_pack_addr(32'(i_rd_state), 32'(i_rd_action), ACTION_BITS));
    assign w_scan_addr = ADDR_WIDTH'(qt_pack_addr(32'(r_mq_state),
                                                  32'(r_scan_cnt[ACTION_BITS-1:0]), ACTION_BITS));

    assign w_rd_accept = i_rd_valid & o_rd_ready;
    assign w_mq_accept = i_mq_valid & o_mq_ready;

    // Scan counter: values 0..NUM_ACTIONS-1 issue reads, values 1..NUM_ACTIONS compare the
    // data returned for action (count-1); the top bit marks the final compare cycle.
    assign w_scan_issue = (r_state == ST_SCAN) && !r_scan_cnt[ACTION_BITS];
    assign w_scan_cmp   = (r_state == ST_SCAN) && (r_scan_cnt != '0);
    assign w_scan_last  = (r_state == ST_SCAN) && r_scan_cnt[ACTION_BITS];
    assign w_cmp_act    = r_scan_cnt[ACTION_BITS-1:0] - 1'b1;

    assign w_rdata = r_fwd_hit ? r_fwd_data : w_ram_rdata;
    assign w_take  = (r_scan_cnt == CNT_W'(1)) ||
                     qt_greater(32'(w_rdata), 32'(r_best_val), DATA_WIDTH, L_SIGNED);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_addr == '1) w_state_nxt = ST_IDLE;
            ST_IDLE: if (w_mq_accept)       w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_scan_last)       w_state_nxt = ST_DONE;
            ST_DONE:                        w_state_nxt = ST_IDLE;
            default:                        w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        o_rd_ready  = 1'b0;
        o_mq_ready  = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_waddr = w_wr_addr;
        w_ram_wdata = i_wr_data;
        w_ram_re    = 1'b0;
        w_ram_raddr = w_rd_addr;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_waddr = r_init_addr;
                w_ram_wdata = '0;
            end
            ST_IDLE: begin
                o_rd_ready = 1'b1;
                o_mq_ready = !i_rd_valid;
                w_ram_we   = i_wr_en;
                w_ram_re   = i_rd_valid;
            end
            ST_SCAN: begin
                w_ram_we    = i_wr_en;
                w_ram_re    = w_scan_issue;
                w_ram_raddr = w_scan_addr;
            end
            default: begin
                w_ram_we = i_wr_en;
            end
        endcase
    end

    qtable_sdp_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_ram_wdata),
        .i_re    (w_ram_re),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_init_addr <= '0;
            r_init_done <= 1'b0;
            r_mq_state  <= '0;
            r_scan_cnt  <= '0;
            r_best_val  <= '0;
            r_best_act  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_hold   <= '0;
            r_fwd_hit   <= 1'b0;
            r_fwd_data  <= '0;
            r_mq_valid  <= 1'b0;
            r_mq_value  <= '0;
            r_mq_action <= '0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_addr <= r_init_addr + 1'b1;
                if (r_init_addr == '1) begin
                    r_init_done <= 1'b1;
                end
            end
            if (w_mq_accept) begin
                r_mq_state <= i_mq_state;
                r_scan_cnt <= '0;
            end else if (r_state == ST_SCAN) begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (w_scan_cmp && w_take) begin
                r_best_val <= w_rdata;
                r_best_act <= w_cmp_act;
            end
            // Forwarding decision is captured on the same edge the RAM samples the read.
            r_fwd_hit  <= w_ram_re && w_ram_we && (w_ram_waddr == w_ram_raddr);
            r_fwd_data <= w_ram_wdata;
            r_rd_valid <= w_rd_accept;
            if (r_rd_valid) begin
                r_rd_hold <= w_rdata;
            end
            r_mq_valid <= w_scan_last;
            if (w_scan_last) begin
                r_mq_value  <= w_take ? w_rdata : r_best_val;
                r_mq_action <= w_take ? w_cmp_act : r_best_act;
            end
        end
    end

    assign o_init_done = r_init_done;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_valid ? w_rdata : r_rd_hold;
    assign o_mq_valid  = r_mq_valid;
    assign o_mq_value  = r_mq_value;
    assign o_mq_action = r_mq_action;

endmodule

// File: tb/tb_qtable_maxq.sv
// tb/tb_qtable_maxq.sv - directed self-checking bench for qtable_maxq (signed and unsigned)
module tb_qtable_maxq;

    localparam int SB = 6;
    localparam int AB = 2;
    localparam int DW = 8;

    logic          i_clk = 1'b0;
    logic          i_rst_n = 1'b0;
    logic          i_rd_valid = 1'b0;
    logic [SB-1:0] i_rd_state = '0;
    logic [AB-1:0] i_rd_action = '0;
    logic          i_wr_en = 1'b0;
    logic [SB-1:0] i_wr_state = '0;
    logic [AB-1:0] i_wr_action = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_mq_valid = 1'b0;
    logic [SB-1:0] i_mq_state = '0;

    logic          o_init_done, o_rd_ready, o_rd_valid, o_mq_ready, o_mq_valid;
    logic [DW-1:0] o_rd_data, o_mq_value;
    logic [AB-1:0] o_mq_action;
    logic          u_init_done, u_rd_ready, u_rd_valid, u_mq_ready, u_mq_valid;
    logic [DW-1:0] u_rd_data, u_mq_value;
    logic [AB-1:0] u_mq_action;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    qtable_maxq #(.STATE_BITS(SB), .ACTION_BITS(AB), .DATA_WIDTH(DW), .SIGNED_Q(1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_init_done(o_init_done),
        .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_state(i_rd_state),
        .i_rd_action(i_rd_action), .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
        .i_wr_en(i_wr_en), .i_wr_state(i_wr_state), .i_wr_action(i_wr_action),
        .i_wr_data(i_wr_data), .i_mq_valid(i_mq_valid), .o_mq_ready(o_mq_ready),
        .i_mq_state(i_mq_state), .o_mq_valid(o_mq_valid), .o_mq_value(o_mq_value),
        .o_mq_action(o_mq_action)
    );

    qtable_maxq #(.STATE_BITS(SB), .ACTION_BITS(AB), .DATA_WIDTH(DW), .SIGNED_Q(0)) u_dut_uns (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .o_init_done(u_init_done),
        .i_rd_valid(i_rd_valid), .o_rd_ready(u_rd_ready), .i_rd_state(i_rd_state),
        .i_rd_action(i_rd_action), .o_rd_valid(u_rd_valid), .o_rd_data(u_rd_data),
        .i_wr_en(i_wr_en), .i_wr_state(i_wr_state), .i_wr_action(i_wr_action),
        .i_wr_data(i_wr_data), .i_mq_valid(i_mq_valid), .o_mq_ready(u_mq_ready),
        .i_mq_state(i_mq_state), .o_mq_valid(u_mq_valid), .o_mq_value(u_mq_value),
        .o_mq_action(u_mq_action)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic wr(input int s, input int a, input int d);
        i_wr_en     = 1'b1;
        i_wr_state  = SB'(s);
        i_wr_action = AB'(a);
        i_wr_data   = DW'(d);
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input int s, input int a, input int d);
        i_rd_valid  = 1'b1;
        i_rd_state  = SB'(s);
        i_rd_action = AB'(a);
        #1 check({tag, "_ready"}, 32'(o_rd_ready), 32'd1);
        tick();
        i_rd_valid = 1'b0;
        check({tag, "_valid"}, 32'(o_rd_valid), 32'd1);
        check(tag, 32'(o_rd_data), 32'(d));
    endtask

    task automatic init_wait(input string tag, input bit poke);
        int n;
        bit saw_mq;
        n = 0;
        saw_mq = 1'b0;
        while (!o_init_done && n < 400) begin
            tick();
            n++;
            if (o_mq_valid) saw_mq = 1'b1;
            if (n == 10) check({tag, "_ready_in_init"}, 32'({o_rd_ready, o_mq_ready}), 32'd0);
            if (poke && n == 100) begin
                i_wr_en = 1'b1; i_wr_state = '0; i_wr_action = '0; i_wr_data = 8'h55;
            end
            if (poke && n == 101) i_wr_en = 1'b0;
        end
        check({tag, "_latency"}, 32'(n), 32'd256);
        check({tag, "_no_mq_valid"}, 32'(saw_mq), 32'd0);
    endtask

    task automatic mq_run(input string tag, input int s, input int ev, input int ea,
                          input int uv, input int ua, input bit inject);
        int k;
        i_mq_valid = 1'b1;
        i_mq_state = SB'(s);
        #1 check({tag, "_mq_ready"}, 32'(o_mq_ready), 32'd1);
        k = 0;
        do begin
            tick();
            k++;
            if (k == 1) begin
                i_mq_valid = 1'b0;
                check({tag, "_scan_readies"}, 32'({o_rd_ready, o_mq_ready}), 32'd0);
            end
            if (inject && k == 2) begin
                i_wr_en = 1'b1; i_wr_state = SB'(s); i_wr_action = 2'd1; i_wr_data = 8'h05;
            end
            if (inject && k == 3) begin
                i_wr_action = 2'd0; i_wr_data = 8'h7F;
            end
            if (inject && k == 4) i_wr_en = 1'b0;
        end while (!o_mq_valid && k < 20);
        check({tag, "_latency"}, 32'(k), 32'd6);
        check({tag, "_value"}, 32'(o_mq_value), 32'(ev));
        check({tag, "_action"}, 32'(o_mq_action), 32'(ea));
        check({tag, "_uns_value"}, 32'(u_mq_value), 32'(uv));
        check({tag, "_uns_action"}, 32'(u_mq_action), 32'(ua));
        check({tag, "_ready_in_done"}, 32'(o_mq_ready), 32'd0);
        tick();
        check({tag, "_pulse_end"}, 32'(o_mq_valid), 32'd0);
        check({tag, "_value_hold"}, 32'(o_mq_value), 32'(ev));
        check({tag, "_ready_again"}, 32'(o_mq_ready), 32'd1);
    endtask

    initial begin
        bit saw_mq;
        repeat (3) tick();
        check("rst_init_done", 32'(o_init_done), 32'd0);
        check("rst_rd_valid", 32'(o_rd_valid), 32'd0);
        check("rst_rd_data", 32'(o_rd_data), 32'd0);
        check("rst_mq_valid", 32'(o_mq_valid), 32'd0);
        check("rst_mq_value", 32'(o_mq_value), 32'd0);
        check("rst_mq_action", 32'(o_mq_action), 32'd0);

        i_rst_n = 1'b1;
        init_wait("init", 1'b1);
        rd("rd_63_3", 63, 3, 0);
        rd("rd_init_write_ignored", 0, 0, 0);

        wr(5, 2, 8'h40);
        rd("rd_5_2", 5, 2, 8'h40);
        tick();
        check("rd_pulse_end", 32'(o_rd_valid), 32'd0);
        check("rd_data_hold", 32'(o_rd_data), 32'h40);

        i_wr_en = 1'b1; i_wr_state = 6'd2; i_wr_action = 2'd3; i_wr_data = 8'h33;
        rd("collide_fwd", 2, 3, 8'h33);
        i_wr_en = 1'b0;
        rd("collide_mem", 2, 3, 8'h33);

        wr(1, 0, 8'h11);
        wr(1, 1, 8'h22);
        rd("b2b_0", 1, 0, 8'h11);
        rd("b2b_1", 1, 1, 8'h22);

        wr(9, 0, 8'h10);
        wr(9, 1, 8'h7F);
        wr(9, 2, 8'h80);
        wr(9, 3, 8'h7F);
        mq_run("mq9", 9, 8'h7F, 1, 8'h80, 2, 1'b0);

        i_rd_valid = 1'b1; i_rd_state = 6'd5; i_rd_action = 2'd2;
        i_mq_valid = 1'b1; i_mq_state = 6'd9;
        #1 check("prio_mq_ready", 32'(o_mq_ready), 32'd0);
        check("prio_rd_ready", 32'(o_rd_ready), 32'd1);
        tick();
        i_rd_valid = 1'b0;
        check("prio_rd_valid", 32'(o_rd_valid), 32'd1);
        check("prio_rd_data", 32'(o_rd_data), 32'h40);
        mq_run("mq_prio", 9, 8'h7F, 1, 8'h80, 2, 1'b0);

        // Scan row becomes {0x10,0x05(forwarded),0x80,0x7F}; late write to action 0 is not seen.
        mq_run("mq_fwd", 9, 8'h7F, 3, 8'h80, 2, 1'b1);
        rd("after_fwd_a1", 9, 1, 8'h05);
        rd("after_fwd_a0", 9, 0, 8'h7F);

        wr(20, 1, 8'hAA);
        i_mq_valid = 1'b1; i_mq_state = 6'd9;
        tick();
        i_mq_valid = 1'b0;
        tick();
        i_rst_n = 1'b0;
        #1 check("midrst_init_done", 32'(o_init_done), 32'd0);
        check("midrst_rd_data", 32'(o_rd_data), 32'd0);
        check("midrst_mq_value", 32'(o_mq_value), 32'd0);
        check("midrst_mq_action", 32'(o_mq_action), 32'd0);
        saw_mq = 1'b0;
        repeat (3) begin
            tick();
            if (o_mq_valid) saw_mq = 1'b1;
        end
        check("midrst_no_mq_valid", 32'(saw_mq), 32'd0);
        i_rst_n = 1'b1;
        init_wait("reinit", 1'b0);
        rd("reinit_20_1", 20, 1, 0);
        rd("reinit_5_2", 5, 2, 0);
        mq_run("mq_zero_tie", 9, 0, 0, 0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
